// File: rtl/ctrl_pipe_chain.sv
// ctrl_pipe_chain: carries one WIDTH-bit decoded control bundle through DEPTH
// pipeline stages (stage 0 = ID/EX), each with a valid bit. The stages can be
// frozen as a whole, stage 0 can take a bubble, and each stage can be flushed.
// Registered occupancy reports how many stages currently hold an instruction.
module ctrl_pipe_chain #(
  parameter int              WIDTH     = 8,
  parameter int              DEPTH     = 3,
  parameter logic [WIDTH-1:0] NOP_VALUE = {WIDTH{1'b0}}
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [WIDTH-1:0]           in_ctrl,
  input  logic                       in_valid,
  input  logic                       freeze,
  input  logic                       bubble,
  input  logic [DEPTH-1:0]           flush,
  output logic [DEPTH*WIDTH-1:0]     out_ctrl,
  output logic [DEPTH-1:0]           out_valid,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  // Packed so that stage k lands at [k*WIDTH +: WIDTH] of out_ctrl.
  logic [DEPTH-1:0][WIDTH-1:0] ctrl_q, ctrl_d;
  logic [DEPTH-1:0]            valid_q, valid_d;
  logic [OCC_W-1:0]            occ_q, occ_d;

  // Next stage contents: hold on freeze, otherwise advance with flush/bubble kills.
  always_comb begin
    ctrl_d  = ctrl_q;
    valid_d = valid_q;
    if (!freeze) begin
      if (bubble || !in_valid || flush[0]) begin
        ctrl_d[0]  = NOP_VALUE;
        valid_d[0] = 1'b0;
      end else begin
        ctrl_d[0]  = in_ctrl;
        valid_d[0] = 1'b1;
      end
      // Flushing a stage does not stop its old content moving on: stage k
      // always samples stage k-1 as it was before the edge.
      for (int k = 1; k < DEPTH; k++) begin
        if (flush[k]) begin
          ctrl_d[k]  = NOP_VALUE;
          valid_d[k] = 1'b0;
        end else begin
          ctrl_d[k]  = ctrl_q[k-1];
          valid_d[k] = valid_q[k-1];
        end
      end
    end
  end

  // Occupancy is the popcount of the next valid vector, so it can never drift
  // from the valid bits (a frozen pipe reproduces the current count).
  always_comb begin
    occ_d = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occ_d = occ_d + OCC_W'(valid_d[k]);
    end
  end

  // Stage registers with asynchronous active-low reset to the empty pipe.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q  <= {DEPTH{NOP_VALUE}};
      valid_q <= '0;
      occ_q   <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
      occ_q   <= occ_d;
    end
  end

  assign out_ctrl  = ctrl_q;
  assign out_valid = valid_q;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// Self-checking bench for ctrl_pipe_chain (WIDTH=8, DEPTH=3): directed
// scenarios with hand-derived expectations, then randomized traffic checked
// against a queue-based model of the pipe.
module tb_ctrl_pipe_chain;

  localparam int WIDTH = 8;
  localparam int DEPTH = 3;
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [WIDTH-1:0] NOP = '0;

  logic                   clock;
  logic                   reset_n;
  logic [WIDTH-1:0]       in_ctrl;
  logic                   in_valid;
  logic                   freeze;
  logic                   bubble;
  logic [DEPTH-1:0]       flush;
  logic [DEPTH*WIDTH-1:0] out_ctrl;
  logic [DEPTH-1:0]       out_valid;
  logic [OCC_W-1:0]       occupancy;

  int checks = 0;
  int errors = 0;
  int edge_no = 0;

  typedef struct {
    logic [WIDTH-1:0] c;
    logic             v;
  } entry_t;

  // model_q[0] is the youngest instruction (stage 0).
  entry_t model_q[$];

  ctrl_pipe_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NOP_VALUE(NOP)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_ctrl   (in_ctrl),
    .in_valid  (in_valid),
    .freeze    (freeze),
    .bubble    (bubble),
    .flush     (flush),
    .out_ctrl  (out_ctrl),
    .out_valid (out_valid),
    .occupancy (occupancy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    entry_t e;
    e.c = NOP;
    e.v = 1'b0;
    model_q.delete();
    for (int i = 0; i < DEPTH; i++) model_q.push_back(e);
  endfunction

  function automatic logic [DEPTH*WIDTH-1:0] model_ctrl();
    logic [DEPTH*WIDTH-1:0] r = '0;
    for (int i = 0; i < DEPTH; i++) r[i*WIDTH +: WIDTH] = model_q[i].c;
    return r;
  endfunction

  function automatic logic [DEPTH-1:0] model_valid();
    logic [DEPTH-1:0] r = '0;
    for (int i = 0; i < DEPTH; i++) r[i] = model_q[i].v;
    return r;
  endfunction

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) n += int'(model_q[i].v);
    return n;
  endfunction

  // Apply one clock edge to the model: new instruction enters at the front,
  // the oldest falls off the end, then flushed slots are emptied.
  function automatic void model_edge();
    entry_t e;
    if (!reset_n) begin
      model_reset();
      return;
    end
    if (freeze) return;
    e.v = in_valid && !bubble;
    e.c = e.v ? in_ctrl : NOP;
    model_q.push_front(e);
    void'(model_q.pop_back());
    for (int i = 0; i < DEPTH; i++) begin
      if (flush[i]) begin
        model_q[i].c = NOP;
        model_q[i].v = 1'b0;
      end
    end
  endfunction

  task automatic drive(input logic v, input logic [WIDTH-1:0] c, input logic frz,
                       input logic bub, input logic [DEPTH-1:0] fl);
    in_valid = v;
    in_ctrl  = c;
    freeze   = frz;
    bubble   = bub;
    flush    = fl;
  endtask

  // One edge: advance the model, then sample outputs 1 time unit later.
  task automatic step();
    @(posedge clock);
    model_edge();
    edge_no++;
    #1;
    $display("edge %0d: rst_n=%b v=%b c=%h frz=%b bub=%b fl=%b -> ctrl=%h valid=%b occ=%0d",
             edge_no, reset_n, in_valid, in_ctrl, freeze, bubble, flush,
             out_ctrl, out_valid, occupancy);
    check("model_ctrl", 64'(out_ctrl), 64'(model_ctrl()));
    check("model_valid", 64'(out_valid), 64'(model_valid()));
    check("model_occ", 64'(occupancy), 64'(model_count()));
  endtask

  initial begin
    logic [WIDTH-1:0] seq[4];
    seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33; seq[3] = 8'h44;

    reset_n = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    model_reset();
    #2 reset_n = 1'b0;
    #2;
    check("reset_ctrl", 64'(out_ctrl), 64'h0);
    check("reset_valid", 64'(out_valid), 64'h0);
    check("reset_occ", 64'(occupancy), 64'h0);

    // Edge with reset still low must keep the pipe empty.
    step();
    #2 reset_n = 1'b1;

    // Stream 0x11..0x44.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, seq[i], 1'b0, 1'b0, '0);
      step();
    end
    check("stream_ctrl", 64'(out_ctrl), 64'h223344);
    check("stream_valid", 64'(out_valid), 64'b111);
    check("stream_occ", 64'(occupancy), 64'd3);

    // Freeze wins over flush, bubble and new input.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'h55, 1'b1, 1'b1, 3'b111);
      step();
      check("freeze_ctrl", 64'(out_ctrl), 64'h223344);
      check("freeze_valid", 64'(out_valid), 64'b111);
      check("freeze_occ", 64'(occupancy), 64'd3);
    end

    // Flush stage 0 only: old stage 0 content still advances.
    drive(1'b1, 8'h55, 1'b0, 1'b0, 3'b001);
    step();
    check("flush_ctrl", 64'(out_ctrl), 64'h334400);
    check("flush_valid", 64'(out_valid), 64'b110);
    check("flush_occ", 64'(occupancy), 64'd2);

    // Invalid input drains the pipe.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'hFF, 1'b0, 1'b0, '0);
      step();
    end
    check("invalid_ctrl", 64'(out_ctrl), 64'h0);
    check("invalid_valid", 64'(out_valid), 64'b000);
    check("invalid_occ", 64'(occupancy), 64'd0);

    // Bubble on the second edge.
    drive(1'b1, 8'hA1, 1'b0, 1'b0, '0);
    step();
    drive(1'b1, 8'hA2, 1'b0, 1'b1, '0);
    step();
    check("bubble_ctrl", 64'(out_ctrl), 64'h00A100);
    check("bubble_valid", 64'(out_valid), 64'b010);
    drive(1'b0, 8'h00, 1'b0, 1'b0, '0);
    step();
    check("bubble2_ctrl", 64'(out_ctrl), 64'hA10000);
    check("bubble2_valid", 64'(out_valid), 64'b100);
    check("bubble2_occ", 64'(occupancy), 64'd1);

    // Bubble together with flush[0]: same as bubble alone.
    drive(1'b1, 8'hB1, 1'b0, 1'b1, 3'b001);
    step();

    // Flush everything while a valid instruction arrives.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0, '0);
      step();
    end
    drive(1'b1, 8'hCC, 1'b0, 1'b0, 3'b111);
    step();
    check("flushall_valid", 64'(out_valid), 64'b000);
    check("flushall_occ", 64'(occupancy), 64'd0);

    // Async reset mid-stream.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'hD0 + 8'(i), 1'b0, 1'b0, '0);
      step();
    end
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check("async_ctrl", 64'(out_ctrl), 64'h0);
    check("async_valid", 64'(out_valid), 64'h0);
    check("async_occ", 64'(occupancy), 64'h0);
    step();
    step();
    reset_n = 1'b1;
    drive(1'b1, 8'h77, 1'b0, 1'b0, '0);
    step();
    check("release_ctrl", 64'(out_ctrl), 64'h000077);
    check("release_valid", 64'(out_valid), 64'b001);
    check("release_occ", 64'(occupancy), 64'd1);

    // Randomized traffic against the model.
    for (int n = 0; n < 200; n++) begin
      logic [DEPTH-1:0] fl;
      for (int k = 0; k < DEPTH; k++) fl[k] = ($urandom_range(0, 9) == 0);
      drive($urandom_range(0, 9) < 8, WIDTH'($urandom),
            $urandom_range(0, 9) == 0, $urandom_range(0, 19) < 3, fl);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
